// File: rtl/clk_div_bank.sv
// clk_div_bank: multi-channel programmable clock-enable divider.
// Each channel divides clk by a runtime-loadable N, giving a 50%-duty
// toggle (clk_out, period 2N) and a one-cycle tick every N cycles.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   en                global count enable (0 freezes counters/outputs)
//   sync              realign all channels to phase 0, apply pending divisors
//   load_valid/ready  divisor write handshake (ready is combinational)
//   load_ch, load_div target channel and new divisor (0 disables)
//   clk_out, tick     per-channel square wave and wrap pulse
//   active            per-channel: active divisor nonzero
module clk_div_bank #(
    parameter int CH       = 4,
    parameter int W        = 8,
    parameter int INIT_DIV = 2,
    localparam int LW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          sync,
    input  logic          load_valid,
    input  logic [LW-1:0] load_ch,
    input  logic [W-1:0]  load_div,
    output logic          load_ready,
    output logic [CH-1:0] clk_out,
    output logic [CH-1:0] tick,
    output logic [CH-1:0] active
);

    logic [W-1:0]  r_div  [CH];
    logic [W-1:0]  r_cnt  [CH];
    logic [W-1:0]  r_pend [CH];
    logic [CH-1:0] r_pend_v;
    logic [CH-1:0] r_clk;
    logic [CH-1:0] r_tick;

    logic          w_ready;
    logic [CH-1:0] w_acc;
    logic [CH-1:0] w_active;

    // Out-of-range channel numbers match no channel, so they see
    // ready=1 and the write is silently dropped.
    always_comb begin
        w_ready = 1'b1;
        w_acc   = '0;
        for (int i = 0; i < CH; i++) begin
            if (load_ch == LW'(i)) begin
                w_ready  = ~r_pend_v[i];
                w_acc[i] = load_valid & ~r_pend_v[i];
            end
        end
    end

    always_comb begin
        w_active = '0;
        for (int i = 0; i < CH; i++) begin
            w_active[i] = |r_div[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (reset) begin
                r_div[i]    <= W'(INIT_DIV);
                r_cnt[i]    <= '0;
                r_pend[i]   <= '0;
                r_pend_v[i] <= 1'b0;
                r_clk[i]    <= 1'b0;
                r_tick[i]   <= 1'b0;
            end else if (sync) begin
                r_cnt[i]    <= '0;
                r_clk[i]    <= 1'b0;
                r_tick[i]   <= 1'b0;
                r_pend_v[i] <= 1'b0;
                // A write landing on the sync edge bypasses the pending slot.
                if (w_acc[i]) begin
                    r_div[i] <= load_div;
                end else if (r_pend_v[i]) begin
                    r_div[i] <= r_pend[i];
                end
            end else begin
                if (w_acc[i]) begin
                    r_pend[i]   <= load_div;
                    r_pend_v[i] <= 1'b1;
                end
                if (r_div[i] == '0) begin
                    // Idle channel: nothing to wrap, so apply pending at once.
                    r_cnt[i]  <= '0;
                    r_clk[i]  <= 1'b0;
                    r_tick[i] <= 1'b0;
                    if (r_pend_v[i]) begin
                        r_div[i]    <= r_pend[i];
                        r_pend_v[i] <= 1'b0;
                    end
                end else if (en) begin
                    if (r_cnt[i] == r_div[i] - 1'b1) begin
                        r_cnt[i]  <= '0;
                        r_tick[i] <= 1'b1;
                        if (r_pend_v[i]) begin
                            r_div[i]    <= r_pend[i];
                            r_pend_v[i] <= 1'b0;
                            // Switching off parks the output low.
                            r_clk[i]    <= (r_pend[i] != '0) ? ~r_clk[i] : 1'b0;
                        end else begin
                            r_clk[i] <= ~r_clk[i];
                        end
                    end else begin
                        r_cnt[i]  <= r_cnt[i] + 1'b1;
                        r_tick[i] <= 1'b0;
                    end
                end else begin
                    r_tick[i] <= 1'b0;
                end
            end
        end
    end

    assign load_ready = w_ready;
    assign clk_out    = r_clk;
    assign tick       = r_tick;
    assign active     = w_active;

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed + random stimulus against an in-bench
// behavioural model of the divider bank; per-cycle output comparison.
module tb_clk_div_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic       load_valid = 1'b0;
    logic [1:0] load_ch = '0;
    logic [7:0] load_div = '0;
    logic       load_ready;
    logic [3:0] clk_out, tick, active;

    logic       load_valid2 = 1'b0;
    logic [1:0] load_ch2 = '0;
    logic [7:0] load_div2 = '0;
    logic       load_ready2;
    logic [2:0] clk_out2, tick2, active2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    clk_div_bank #(.CH(4), .W(8), .INIT_DIV(2)) u_dut (
        .clk(clk), .reset(reset), .en(en), .sync(sync),
        .load_valid(load_valid), .load_ch(load_ch), .load_div(load_div),
        .load_ready(load_ready), .clk_out(clk_out), .tick(tick),
        .active(active)
    );

    clk_div_bank #(.CH(3), .W(8), .INIT_DIV(2)) u_dut3 (
        .clk(clk), .reset(reset), .en(en), .sync(1'b0),
        .load_valid(load_valid2), .load_ch(load_ch2), .load_div(load_div2),
        .load_ready(load_ready2), .clk_out(clk_out2), .tick(tick2),
        .active(active2)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: per channel divisor, position within the
    // period, one pending slot, output level and tick.
    int m_div[4], m_pos[4], m_pend[4];
    bit m_pv[4], m_co[4], m_tk[4];

    always @(posedge clk) begin
        int lc;
        bit acc;
        lc  = int'(load_ch);
        acc = load_valid && !m_pv[lc];
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                m_div[i] = 2; m_pos[i] = 0; m_pv[i] = 0;
                m_co[i] = 0; m_tk[i] = 0;
            end else if (sync) begin
                m_pos[i] = 0; m_co[i] = 0; m_tk[i] = 0;
                if (m_pv[i]) m_div[i] = m_pend[i];
                m_pv[i] = 0;
                if (acc && lc == i) m_div[i] = int'(load_div);
            end else begin
                if (m_div[i] == 0) begin
                    m_pos[i] = 0; m_co[i] = 0; m_tk[i] = 0;
                    if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 0; end
                end else if (en) begin
                    m_pos[i] = (m_pos[i] + 1) % m_div[i];
                    m_tk[i]  = (m_pos[i] == 0);
                    if (m_tk[i]) begin
                        m_co[i] = !m_co[i];
                        if (m_pv[i]) begin
                            m_div[i] = m_pend[i];
                            m_pv[i]  = 0;
                            if (m_div[i] == 0) m_co[i] = 0;
                        end
                    end
                end else begin
                    m_tk[i] = 0;
                end
                if (acc && lc == i) begin m_pend[i] = int'(load_div); m_pv[i] = 1; end
            end
        end
        chk_en = 1;
    end

    always @(negedge clk) begin
        logic [3:0] e_co, e_tk, e_ac;
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                e_co[i] = m_co[i];
                e_tk[i] = m_tk[i];
                e_ac[i] = (m_div[i] != 0);
            end
            chk("clk_out", 32'(clk_out), 32'(e_co));
            chk("tick", 32'(tick), 32'(e_tk));
            chk("active", 32'(active), 32'(e_ac));
            chk("load_ready", 32'(load_ready), 32'(!m_pv[int'(load_ch)]));
        end
    end

    task automatic do_load(input int ch, input int dv);
        bit acc;
        bit done;
        done = 0;
        load_valid = 1; load_ch = 2'(ch); load_div = 8'(dv);
        for (int n = 0; n < 40 && !done; n++) begin
            #1 acc = load_ready;
            @(posedge clk); #1;
            done = acc;
        end
        load_valid = 0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL load_timeout ch %0d got stalled expected accept", ch);
        end
    endtask

    initial begin
        int f0, f1;
        reset = 1;
        load_valid2 = 1; load_ch2 = 2'd3; load_div2 = 8'd0;
        repeat (3) @(posedge clk);
        #1 reset = 0; en = 1;
        @(posedge clk); #2;
        chk("e1_tick", 32'(tick), 32'h0);
        chk("e1_clk", 32'(clk_out), 32'h0);
        chk("e1_active", 32'(active), 32'hF);
        chk("oor_ready", 32'(load_ready2), 32'h1);
        @(posedge clk); #2;
        chk("e2_tick", 32'(tick), 32'hF);
        chk("e2_clk", 32'(clk_out), 32'hF);
        chk("oor_tick", 32'(tick2), 32'h7);
        @(posedge clk); #2;
        chk("e3_tick", 32'(tick), 32'h0);
        chk("e3_clk", 32'(clk_out), 32'hF);
        @(posedge clk); #2;
        chk("e4_tick", 32'(tick), 32'hF);
        chk("e4_clk", 32'(clk_out), 32'h0);
        chk("oor_active", 32'(active2), 32'h7);
        load_valid2 = 0;

        // Back-to-back loads to ch1: second stalls until first applies.
        load_valid = 1; load_ch = 2'd1; load_div = 8'd5;
        @(posedge clk); #2;
        load_div = 8'd3;
        chk("stall_ready", 32'(load_ready), 32'h0);
        do_load(1, 3);
        repeat (20) @(posedge clk);
        #1;

        // ch2 off, then N=1.
        do_load(2, 0);
        repeat (6) @(posedge clk);
        #2 chk("ch2_off", 32'(active[2]), 32'h0);
        do_load(2, 1);
        repeat (3) @(posedge clk);
        #2 chk("ch2_n1_tick", 32'(tick[2]), 32'h1);
        @(posedge clk);
        #2 chk("ch2_n1_tick2", 32'(tick[2]), 32'h1);

        // Freeze with a load during freeze.
        en = 0;
        do_load(0, 4);
        repeat (6) @(posedge clk);
        #1 en = 1;
        repeat (15) @(posedge clk);
        #1;

        // Realign at 3,4,5,6 then sync with same-cycle ch0 N=7.
        do_load(0, 3); do_load(1, 4); do_load(2, 5); do_load(3, 6);
        sync = 1;
        @(posedge clk); #1 sync = 0;
        repeat (19) @(posedge clk);
        #1 sync = 1; load_valid = 1; load_ch = 2'd0; load_div = 8'd7;
        @(posedge clk); #2;
        chk("sync_clk", 32'(clk_out), 32'h0);
        chk("sync_tick", 32'(tick), 32'h0);
        sync = 0; load_valid = 0;
        f0 = 0; f1 = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #2;
            if (tick[0] && f0 == 0) f0 = i;
            if (tick[1] && f1 == 0) f1 = i;
        end
        chk("sync_first_tick0", 32'(f0), 32'd7);
        chk("sync_first_tick1", 32'(f1), 32'd4);

        // Reset with a pending write.
        do_load(3, 9);
        load_ch = 2'd3; reset = 1;
        @(posedge clk); #2;
        chk("rst_ready", 32'(load_ready), 32'h1);
        chk("rst_active", 32'(active), 32'hF);
        chk("rst_clk", 32'(clk_out), 32'h0);
        reset = 0; en = 1;
        repeat (2) @(posedge clk);
        #2 chk("rst_e2_tick", 32'(tick), 32'hF);

        // Random phase.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            en         = ($urandom % 10) != 0;
            sync       = ($urandom % 60) == 0;
            reset      = ($urandom % 400) == 0;
            load_valid = ($urandom % 3) == 0;
            load_ch    = 2'($urandom % 4);
            load_div   = 8'($urandom % 8);
        end
        @(posedge clk); #1;
        load_valid = 0; sync = 0; reset = 0;
        repeat (3) @(posedge clk);
        #6;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
